// File: rtl/xyz_pkg.sv
// Shared definitions for the xyz sequencer code checker.
// Holds state encoding, legal code constants, next-code and phase helpers.
package xyz_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [2:0] CODE0 = 3'b000;
  localparam logic [2:0] CODE1 = 3'b001;
  localparam logic [2:0] CODE2 = 3'b010;
  localparam logic [2:0] CODE3 = 3'b100;

  function automatic logic code_legal(
    input logic [2:0] c
  );
    return (c == CODE0) || (c == CODE1) ||
           (c == CODE2) || (c == CODE3);
  endfunction

  // Illegal codes map to CODE0; callers only
  // advance from a known legal code.
  function automatic logic [2:0] next_code(
    input logic [2:0] c
  );
    logic [2:0] n;
    n = CODE0;
    case (c)
      CODE0:   n = CODE1;
      CODE1:   n = CODE2;
      CODE2:   n = CODE3;
      default: n = CODE0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] code_phase(
    input logic [2:0] c
  );
    logic [1:0] p;
    p = 2'd0;
    case (c)
      CODE1:   p = 2'd1;
      CODE2:   p = 2'd2;
      CODE3:   p = 2'd3;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/xyz_code_decode.sv
// Combinational code decoder: maps a 3-bit code to {legal, phase}.
// Ports: i_code (code in), o_legal (code is in the cycle), o_phase (index).
module xyz_code_decode
  import xyz_pkg::*;
(
  input  logic [2:0] i_code,
  output logic       o_legal,
  output logic [1:0] o_phase
);

  assign o_legal = code_legal(i_code);
  assign o_phase = code_phase(i_code);

endmodule

// File: rtl/xyz_seq_checker.sv
// Sequence lock checker for the cyclic code 000->001->010->100.
// Ports: clk, rst (async high), xyz_in/xyz_valid (sample), clr_cnt,
//        locked, phase, err (mismatch pulse), err_cnt (saturating).
module xyz_seq_checker
  import xyz_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 4,
  parameter int unsigned LOSS_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] xyz_in,
  input  logic       xyz_valid,
  input  logic       clr_cnt,
  output logic       locked,
  output logic [1:0] phase,
  output logic       err,
  output logic [7:0] err_cnt
);

  state_t     r_state;
  logic [2:0] r_exp;
  logic [3:0] r_match_cnt;
  logic [3:0] r_miss_cnt;

  logic       w_legal;
  logic [1:0] w_phase;
  logic       w_match;
  logic       w_err_now;
  logic [3:0] w_match_inc;
  logic [3:0] w_miss_inc;

  xyz_code_decode u_dec (
    .i_code  (xyz_in),
    .o_legal (w_legal),
    .o_phase (w_phase)
  );

  // r_exp is always a legal code, so an
  // illegal input can never match.
  assign w_match     = (xyz_in == r_exp);
  assign w_err_now   = xyz_valid &&
                       (r_state == ST_LOCKED) &&
                       !w_match;
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_exp       <= CODE0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      locked      <= 1'b0;
      phase       <= 2'd0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (xyz_valid) begin
        unique case (r_state)
          ST_HUNT: begin
            if (w_legal) begin
              r_exp       <= next_code(xyz_in);
              r_match_cnt <= 4'd1;
              phase       <= w_phase;
              r_state     <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (w_match) begin
              r_match_cnt <= w_match_inc;
              r_exp       <= next_code(r_exp);
              phase       <= w_phase;
              if (w_match_inc == 4'(SYNC_LEN)) begin
                r_state    <= ST_LOCKED;
                locked     <= 1'b1;
                r_miss_cnt <= 4'd0;
              end
            end else if (w_legal) begin
              // re-seed on a legal code out of order
              r_exp       <= next_code(xyz_in);
              r_match_cnt <= 4'd1;
              phase       <= w_phase;
            end else begin
              r_match_cnt <= 4'd0;
              r_state     <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            // flywheel: expected code advances
            // whether or not the sample matched
            r_exp <= next_code(r_exp);
            if (w_match) begin
              phase      <= w_phase;
              r_miss_cnt <= 4'd0;
            end else begin
              err        <= 1'b1;
              r_miss_cnt <= w_miss_inc;
              if (w_miss_inc == 4'(LOSS_LEN)) begin
                r_state     <= ST_HUNT;
                locked      <= 1'b0;
                r_match_cnt <= 4'd0;
                r_miss_cnt  <= 4'd0;
              end
            end
          end
          default: begin
            r_state <= ST_HUNT;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

  // clear wins over hold but not over an
  // error landing on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (clr_cnt) begin
      err_cnt <= {7'd0, w_err_now};
    end else if (w_err_now && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
